// File: rtl/cardinal_ring_router.sv
// Three-port (cw/ccw/PE) ring router; polarity time-multiplexes even/odd VCs over one-entry buffers.
// Capture to send is 2 cycles without contention; a full buffer holds ri=0 / so=1 until drained, nothing is dropped.
module cardinal_ring_router #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              cwsi,
    input  logic              ccwsi,
    input  logic              pesi,
    output logic              cwri,
    output logic              ccwri,
    output logic              peri,
    input  logic [0:DATA_W-1] cwdi,
    input  logic [0:DATA_W-1] ccwdi,
    input  logic [0:DATA_W-1] pedi,
    output logic              cwso,
    output logic              ccwso,
    output logic              peso,
    input  logic              cwro,
    input  logic              ccwro,
    input  logic              pero,
    output logic [0:DATA_W-1] cwdo,
    output logic [0:DATA_W-1] ccwdo,
    output logic [0:DATA_W-1] pedo
);
    localparam int NP = 3;
    typedef logic [0:DATA_W-1] pkt_t;

    // Per output: requester A (ring input, favoured after reset) and requester B.
    localparam logic [1:0] SRC_A [NP] = '{2'd0, 2'd1, 2'd0};
    localparam logic [1:0] SRC_B [NP] = '{2'd2, 2'd2, 2'd1};

    logic          pol_q, pol_d;
    logic          ivc;
    logic [1:0]    in_vld_q  [NP];
    logic [1:0]    in_vld_d  [NP];
    pkt_t          in_dat_q  [NP][2];
    pkt_t          in_dat_d  [NP][2];
    logic [1:0]    out_vld_q [NP];
    logic [1:0]    out_vld_d [NP];
    pkt_t          out_dat_q [NP][2];
    pkt_t          out_dat_d [NP][2];
    logic [1:0]    ptr_q     [NP];
    logic [1:0]    ptr_d     [NP];

    logic [NP-1:0] si, ro, ri, so;
    logic [NP-1:0] req_a, req_b, gnt_a, gnt_b;
    logic [NP-1:0] dst_oh [NP];
    pkt_t          di     [NP];
    pkt_t          dout   [NP];
    pkt_t          fwd    [NP];

    assign si    = {pesi, ccwsi, cwsi};
    assign ro    = {pero, ccwro, cwro};
    assign di[0] = cwdi;
    assign di[1] = ccwdi;
    assign di[2] = pedi;
    assign ivc   = ~pol_q;

    assign polarity = pol_q;
    assign {peri, ccwri, cwri} = ri;
    assign {peso, ccwso, cwso} = so;
    assign cwdo  = dout[0];
    assign ccwdo = dout[1];
    assign pedo  = dout[2];

    always_comb begin
        for (int x = 0; x < NP; x++) begin
            ri[x]   = ~in_vld_q[x][pol_q];
            so[x]   = out_vld_q[x][pol_q];
            dout[x] = so[x] ? out_dat_q[x][pol_q] : '0;
        end
    end

    // Route the internal-phase VC of every input and arbitrate each output.
    always_comb begin
        for (int x = 0; x < NP; x++) begin
            fwd[x]    = in_dat_q[x][ivc];
            dst_oh[x] = '0;
            if (x == NP - 1) begin
                dst_oh[x] = fwd[x][1] ? 3'b010 : 3'b001;
            end else if (fwd[x][8:15] == 8'h00) begin
                dst_oh[x] = 3'b100;
            end else begin
                dst_oh[x][x]  = 1'b1;
                fwd[x][8:15]  = fwd[x][8:15] >> 1;
            end
        end
        for (int y = 0; y < NP; y++) begin
            req_a[y] = in_vld_q[SRC_A[y]][ivc] && dst_oh[SRC_A[y]][y];
            req_b[y] = in_vld_q[SRC_B[y]][ivc] && dst_oh[SRC_B[y]][y];
            gnt_b[y] = !out_vld_q[y][ivc] && req_b[y] && (!req_a[y] || ptr_q[y][ivc]);
            gnt_a[y] = !out_vld_q[y][ivc] && req_a[y] && !gnt_b[y];
        end
    end

    always_comb begin
        pol_d     = ~pol_q;
        in_vld_d  = in_vld_q;
        in_dat_d  = in_dat_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        ptr_d     = ptr_q;
        for (int x = 0; x < NP; x++) begin
            if (si[x] && ri[x]) begin
                in_vld_d[x][pol_q] = 1'b1;
                in_dat_d[x][pol_q] = di[x];
            end
            if (so[x] && ro[x]) begin
                out_vld_d[x][pol_q] = 1'b0;
            end
        end
        for (int y = 0; y < NP; y++) begin
            if (gnt_a[y] || gnt_b[y]) begin
                out_vld_d[y][ivc] = 1'b1;
                out_dat_d[y][ivc] = gnt_b[y] ? fwd[SRC_B[y]] : fwd[SRC_A[y]];
                if (gnt_b[y]) begin
                    in_vld_d[SRC_B[y]][ivc] = 1'b0;
                end else begin
                    in_vld_d[SRC_A[y]][ivc] = 1'b0;
                end
                if (req_a[y] && req_b[y]) begin
                    ptr_d[y][ivc] = ~ptr_q[y][ivc];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pol_q <= 1'b0;
            for (int x = 0; x < NP; x++) begin
                in_vld_q[x]  <= '0;
                out_vld_q[x] <= '0;
                ptr_q[x]     <= '0;
                for (int v = 0; v < 2; v++) begin
                    in_dat_q[x][v]  <= '0;
                    out_dat_q[x][v] <= '0;
                end
            end
        end else begin
            pol_q     <= pol_d;
            in_vld_q  <= in_vld_d;
            in_dat_q  <= in_dat_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            ptr_q     <= ptr_d;
        end
    end
endmodule

// File: tb/tb_cardinal_ring_router.sv
// Directed vector table plus hand sequences for backpressure, mid-run reset and mixed-VC traffic.
module tb_cardinal_ring_router;
    typedef logic [0:63] pkt_t;

    typedef struct packed {
        logic [2:0] si;
        pkt_t       cwdi;
        pkt_t       ccwdi;
        pkt_t       pedi;
        logic       pol;
        logic [2:0] ri;
        logic [2:0] so;
        pkt_t       cwdo;
        pkt_t       ccwdo;
        pkt_t       pedo;
    } vec_t;

    typedef struct packed {
        logic [1:0] port;
        pkt_t       d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic polarity;
    logic cwsi = 0, ccwsi = 0, pesi = 0;
    logic cwri, ccwri, peri;
    pkt_t cwdi = '0, ccwdi = '0, pedi = '0;
    logic cwso, ccwso, peso;
    logic cwro = 1, ccwro = 1, pero = 1;
    pkt_t cwdo, ccwdo, pedo;

    int   nchk = 0;
    int   nerr = 0;
    logic exp_pol = 1'b0;
    vec_t tbl[$];
    exp_t sb[$];

    cardinal_ring_router #(.DATA_W(64)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .cwsi(cwsi), .ccwsi(ccwsi), .pesi(pesi),
        .cwri(cwri), .ccwri(ccwri), .peri(peri),
        .cwdi(cwdi), .ccwdi(ccwdi), .pedi(pedi),
        .cwso(cwso), .ccwso(ccwso), .peso(peso),
        .cwro(cwro), .ccwro(ccwro), .pero(pero),
        .cwdo(cwdo), .ccwdo(ccwdo), .pedo(pedo)
    );

    always #5 clk = ~clk;

    function automatic pkt_t mk(input logic vc, input logic dir, input logic [7:0] hop, input logic [47:0] pl);
        pkt_t d;
        d = '0;
        d[0] = vc;
        d[1] = dir;
        d[8:15] = hop;
        d[16:63] = pl;
        return d;
    endfunction

    function automatic vec_t v(input logic [2:0] si, input pkt_t a, input pkt_t b, input pkt_t c,
                               input logic pol, input logic [2:0] ri, input logic [2:0] so,
                               input pkt_t oa, input pkt_t ob, input pkt_t oc);
        vec_t r;
        r.si = si; r.cwdi = a; r.ccwdi = b; r.pedi = c;
        r.pol = pol; r.ri = ri; r.so = so;
        r.cwdo = oa; r.ccwdo = ob; r.pedo = oc;
        return r;
    endfunction

    function automatic exp_t route(input int x, input pkt_t d);
        exp_t e;
        e.d = d;
        if (x == 2) e.port = d[1] ? 2'd1 : 2'd0;
        else if (d[8:15] == 8'h00) e.port = 2'd2;
        else begin
            e.port = 2'(x);
            e.d[8:15] = d[8:15] >> 1;
        end
        return e;
    endfunction

    function automatic pkt_t get_do(input int y);
        case (y)
            0: return cwdo;
            1: return ccwdo;
            default: return pedo;
        endcase
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input pkt_t act, input pkt_t exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        exp_pol = ~exp_pol;
    endtask

    task automatic do_reset;
        {pesi, ccwsi, cwsi} = '0;
        {pero, ccwro, cwro} = 3'b111;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_pol = 1'b0;
    endtask

    initial begin
        pkt_t z, a, b, bx, c1, c1x, p1, p2, c2, c2x, d1, d1x, d2, d2x, d3, e;
        int pid;
        z   = '0;
        a   = mk(0, 0, 8'h00, 48'h0000_0000_A1A1);
        b   = mk(0, 1, 8'h06, 48'h0000_0000_B2B2);
        bx  = mk(0, 1, 8'h03, 48'h0000_0000_B2B2);
        c1  = mk(0, 0, 8'h04, 48'h0000_0000_C1C1);
        c1x = mk(0, 0, 8'h02, 48'h0000_0000_C1C1);
        p1  = mk(0, 0, 8'h55, 48'h0000_0000_D1D1);
        p2  = mk(0, 0, 8'h00, 48'h0000_0000_D2D2);
        c2  = mk(0, 0, 8'h10, 48'h0000_0000_C2C2);
        c2x = mk(0, 0, 8'h08, 48'h0000_0000_C2C2);
        d1  = mk(0, 0, 8'h02, 48'h0000_0000_E1E1);
        d1x = mk(0, 0, 8'h01, 48'h0000_0000_E1E1);
        d2  = mk(0, 0, 8'h08, 48'h0000_0000_E2E2);
        d2x = mk(0, 0, 8'h04, 48'h0000_0000_E2E2);
        d3  = mk(0, 0, 8'h0C, 48'h0000_0000_E3E3);
        e   = mk(1, 0, 8'h00, 48'h0000_0000_F0F0);

        // cycle-by-cycle table, ro held at 1, si/ri/so bit order {pe, ccw, cw}
        tbl.push_back(v(3'b001, a,  z, z,  0, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  1, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  0, 3'b111, 3'b100, z,   z,  a));
        tbl.push_back(v(3'b000, z,  z, z,  1, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b010, z,  b, z,  0, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  1, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  0, 3'b111, 3'b010, z,   bx, z));
        tbl.push_back(v(3'b000, z,  z, z,  1, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b101, c1, z, p1, 0, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  1, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  0, 3'b011, 3'b001, c1x, z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  1, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b101, c2, z, p2, 0, 3'b111, 3'b001, p1,  z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  1, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  0, 3'b110, 3'b001, p2,  z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  1, 3'b111, 3'b000, z,   z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  0, 3'b111, 3'b001, c2x, z,  z));
        tbl.push_back(v(3'b000, z,  z, z,  1, 3'b111, 3'b000, z,   z,  z));

        reset = 1'b0;
        #1;
        chk1("reset pol", polarity, 1'b0);
        chk3("reset ri", {peri, ccwri, cwri}, 3'b111);
        chk3("reset so", {peso, ccwso, cwso}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_pol = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            {pesi, ccwsi, cwsi} = tbl[i].si;
            cwdi  = tbl[i].cwdi;
            ccwdi = tbl[i].ccwdi;
            pedi  = tbl[i].pedi;
            chk1($sformatf("vec%0d pol", i), polarity, tbl[i].pol);
            chk3($sformatf("vec%0d ri", i), {peri, ccwri, cwri}, tbl[i].ri);
            chk3($sformatf("vec%0d so", i), {peso, ccwso, cwso}, tbl[i].so);
            chkd($sformatf("vec%0d cwdo", i), cwdo, tbl[i].cwdo);
            chkd($sformatf("vec%0d ccwdo", i), ccwdo, tbl[i].ccwdo);
            chkd($sformatf("vec%0d pedo", i), pedo, tbl[i].pedo);
            step;
        end

        // cw-through backpressure: cwro low for twelve cycles
        do_reset;
        cwro = 1'b0; cwsi = 1'b1; cwdi = d1;
        chk1("bp t0 cwri", cwri, 1'b1);
        step;
        cwsi = 1'b0;
        step;
        chk1("bp t2 cwso", cwso, 1'b1);
        chkd("bp t2 cwdo", cwdo, d1x);
        chk1("bp t2 cwri", cwri, 1'b1);
        cwsi = 1'b1; cwdi = d2;
        step;
        cwsi = 1'b0;
        step;
        for (int t = 4; t < 12; t++) begin
            if (t % 2 == 0) begin
                cwsi = 1'b1; cwdi = d3;
                chk1($sformatf("bp t%0d cwso", t), cwso, 1'b1);
                chkd($sformatf("bp t%0d cwdo", t), cwdo, d1x);
                chk1($sformatf("bp t%0d cwri", t), cwri, 1'b0);
            end else begin
                cwsi = 1'b0;
                chk1($sformatf("bp t%0d cwso", t), cwso, 1'b0);
                chk1($sformatf("bp t%0d cwri", t), cwri, 1'b1);
            end
            step;
        end
        cwsi = 1'b0; cwro = 1'b1;
        chk1("bp t12 cwso", cwso, 1'b1);
        chkd("bp t12 cwdo", cwdo, d1x);
        chk1("bp t12 cwri", cwri, 1'b0);
        step;
        chk1("bp t13 cwso", cwso, 1'b0);
        step;
        chk1("bp t14 cwso", cwso, 1'b1);
        chkd("bp t14 cwdo", cwdo, d2x);
        chk1("bp t14 cwri", cwri, 1'b1);
        step;
        step;
        chk3("bp t16 so", {peso, ccwso, cwso}, 3'b000);

        // mid-run reset with a VC1 packet on the PE output
        do_reset;
        step;
        cwsi = 1'b1; cwdi = e;
        step;
        cwsi = 1'b0;
        step;
        chk1("mr pol", polarity, 1'b1);
        chk1("mr peso", peso, 1'b1);
        chkd("mr pedo", pedo, e);
        #2;
        reset = 1'b0;
        #1;
        chk1("mr rst peso", peso, 1'b0);
        chkd("mr rst pedo", pedo, z);
        chk1("mr rst pol", polarity, 1'b0);
        chk1("mr rst cwri", cwri, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_pol = 1'b0;

        // mixed VC traffic on all inputs every cycle, random output readiness
        pid = 0;
        for (int c = 0; c < 70; c++) begin
            pkt_t dv [3];
            logic [2:0] r;
            logic [2:0] s;
            logic [2:0] o;
            logic [2:0] rdy;
            bit found;
            for (int x = 0; x < 3; x++) begin
                logic [7:0] h;
                h = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                dv[x] = mk(exp_pol, 1'($urandom_range(0, 1)), h, {16'h0, 32'(pid)});
                pid++;
            end
            s = (c < 40) ? 3'b111 : 3'b000;
            rdy = (c < 40) ? 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7)) : 3'b111;
            {pesi, ccwsi, cwsi} = s;
            {pero, ccwro, cwro} = rdy;
            cwdi = dv[0]; ccwdi = dv[1]; pedi = dv[2];
            chk1($sformatf("mix c%0d pol", c), polarity, exp_pol);
            r = {peri, ccwri, cwri};
            for (int x = 0; x < 3; x++)
                if (s[x] && r[x]) sb.push_back(route(x, dv[x]));
            o = {peso, ccwso, cwso};
            for (int y = 0; y < 3; y++) begin
                pkt_t got;
                got = get_do(y);
                if (o[y]) begin
                    chk1($sformatf("mix c%0d out%0d vc", c, y), got[0], exp_pol);
                    if (rdy[y]) begin
                        found = 0;
                        for (int k = 0; k < sb.size(); k++) begin
                            if (!found && sb[k].port == 2'(y) && sb[k].d == got) begin
                                found = 1;
                                sb.delete(k);
                            end
                        end
                        nchk++;
                        if (!found) begin
                            nerr++;
                            $display("FAIL mix c%0d out%0d unexpected packet: got %h want one routed to this port", c, y, got);
                        end
                    end
                end else begin
                    chkd($sformatf("mix c%0d out%0d idle do", c, y), got, z);
                end
            end
            step;
        end
        nchk++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL mix drain: got %0d packets undelivered want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/cardinal_ring_router.md
Name: cardinal_ring_router

Overview:
- Three-port bidirectional ring router paired one-to-one with each NIC in the cardinal ring CMP.
- Its PE port drives the NIC's net_si/net_ri/net_di and net_polarity inputs, and consumes the NIC's net_so/net_ro/net_do.
- Its clockwise (cw) and counter-clockwise (ccw) ports link to the neighbouring routers.
- It uses even/odd virtual channels (VCs) time-multiplexed by a global polarity bit, one-entry buffers per VC per port, and round-robin switch arbitration.

Parameters:
- DATA_W, 64, packet width. Bit 0 = vc, bit 1 = dir (0 cw, 1 ccw), bits [8:15] = hop field, bits [16:63] = payload/source (opaque).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- polarity  out  1  current-cycle polarity, routed to NIC net_polarity
- cwsi / ccwsi / pesi  in  1 each  send request on cw / ccw / PE input
- cwri / ccwri / peri  out  1 each  ready on cw / ccw / PE input
- cwdi / ccwdi / pedi  in  DATA_W each  input data, [0:63]
- cwso / ccwso / peso  out  1 each  send on cw / ccw / PE output
- cwro / ccwro / pero  in  1 each  downstream ready on cw / ccw / PE output
- cwdo / ccwdo / pedo  out  DATA_W each  output data, [0:63]

Behaviour:
- Reset (reset=0, async): polarity=0; all 12 buffers (3 inputs x 2 VCs, 3 outputs x 2 VCs) empty; all so=0, all do=0; all arbiter pointers favour ring input.
- polarity toggles on every rising clk edge after reset is released.
- In a cycle with polarity p:
  - External phase, VC p only: input X ri = inbuf[X][p] empty. On the edge, si&&ri captures di into inbuf[X][p]; the vc bit of di is ignored, and senders must send only vc==p packets. Output Y so = outbuf[Y][p] full; do = its contents, else 0. On the edge, so&&ro empties outbuf[Y][p].
  - Internal phase, VC !p only: full input buffers move into empty output buffers of the same VC on the edge.
- Routing:
  - cw input, hop==0 -> PE output; hop!=0 -> cw output with hop shifted right 1 (logical, zero-fill).
  - ccw input: same rule, with the ccw output in place of cw.
  - PE input: dir=0 -> cw output, dir=1 -> ccw output; packet forwarded unmodified.
- Contention, per output per VC:
  - cwo requesters: cw input and PE input. ccwo requesters: ccw input and PE input. peo requesters: cw input and ccw input.
  - 2-way round-robin; the pointer flips only when a grant occurs with both requesting.
  - A loser stays in its input buffer and retries on the next same-VC internal phase.
  - A move needs the target output buffer empty at the start of the cycle. No same-cycle free-and-refill: an output emptied by so&&ro belongs to the other VC anyway.
- Latency: capture at edge E0 (polarity p) -> switch move at E1 -> so=1 during the cycle after E1 (polarity p again). Minimum 2 cycles from capture to so, assuming no contention.
- Backpressure: if ro=0, the output buffer holds, the input buffer cannot drain, and ri stays 0 for that VC. Nothing is dropped or duplicated.
- Simultaneous capture and drain of the same input VC cannot occur; the phases are disjoint by polarity.
- Reset mid-operation: all in-flight packets are discarded, and outputs reach their reset values without waiting for a clock edge.

Test Plan:
- Reset release, idle: polarity toggles 0,1,0,1. All ri=1, all so=0, all do=0. Assert reset mid-run -> so drops immediately and polarity=0.
- cw inject at polarity 0, vc=0, hop=8'h00 -> peso=1 with pedo identical to the input, 2 cycles after capture, at polarity 0.
- ccw inject, hop=8'h06 -> ccwso=1 after 2 cycles, ccwdo hop field=8'h03, all other bits unchanged.
- PE inject, dir=0, and cw inject, hop=8'h04, in the same cycle, same VC -> first cwo packet is the cw-origin one (hop 8'h02), PE packet follows 2 cycles later. Repeat the collision -> PE packet wins this time.
- cwro held 0 for 10 cycles with one cw-through packet buffered -> cwso stays 1 and cwdo stable. A second same-VC cw packet is accepted into inbuf; a third sees cwri=0 on that VC's phases. Release cwro -> both packets delivered in order, none lost.
- Alternate vc=0 and vc=1 injections on every cycle on all three inputs -> every packet exits on its routed port with vc matching the polarity at which it is sent; no so on a VC in the wrong phase.
